// File: rtl/dncntr_pkg.sv
// Shared FSM state encoding for the exercise-set counters.
// The up counter imports the same constants.
package dncntr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/dncntr.sv
// Loadable synchronous down counter with terminal-count, underflow and busy flags.
// WRAP selects wrap-to-RELOAD on underflow or stopping at zero in ST_DONE.
module dncntr
    import dncntr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 2,
    parameter logic [WIDTH-1:0] RELOAD = {WIDTH{1'b1}},
    parameter bit               WRAP   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             out,
    output logic             uflow,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic             uflow_d;

    always_comb begin
        state_d = state_q;
        count_d = count;
        uflow_d = 1'b0;
        if (load) begin
            // load_val==0 still parks in IDLE; the next enable decides wrap or DONE
            state_d = ST_IDLE;
            count_d = load_val;
        end else begin
            case (state_q)
                ST_IDLE, ST_COUNT: begin
                    if (in) begin
                        if (count == '0) begin
                            if (WRAP) begin
                                count_d = RELOAD;
                                uflow_d = 1'b1;
                                state_d = ST_COUNT;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = count - 1'b1;
                            state_d = (!WRAP && count_d == '0) ? ST_DONE : ST_COUNT;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Flags come from next-state values so they move on the same edge as count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count   <= RELOAD;
            out     <= (RELOAD == '0);
            uflow   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            out     <= (count_d == '0);
            uflow   <= uflow_d;
            busy    <= (state_d == ST_COUNT);
        end
    end

endmodule
